// File: rtl/dfft_sched_pkg.sv
// Shared types and constants for the DFFT pulse scheduler.
package dfft_sched_pkg;

    // Transaction sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SET  = 3'd1,
        ST_GAP  = 3'd2,
        ST_CLK  = 3'd3,
        ST_WAIT = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    // Default parameter values.
    localparam int unsigned DEF_NREQ        = 4;
    localparam int unsigned DEF_SET_CLK_GAP = 2;
    localparam int unsigned DEF_OUT_LAT     = 8;
    localparam int unsigned DEF_CT_GUARD    = 2;

    // Counter widths: gap and guard share one width, wait is wider.
    localparam int unsigned GAP_W  = 4;
    localparam int unsigned WAIT_W = 5;

endpackage

// File: rtl/dfft_pulse_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (wrapping) wins.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win,
    output logic [$clog2(NREQ)-1:0] win_id,
    output logic                    any
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [IDW-1:0] idx_s;
    logic           found_s;

    // Scan requesters starting from the pointer and take the first one set.
    always_comb begin
        win     = '0;
        win_id  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = IDW'((int'(ptr) + k) % NREQ);
            if (!found_s && req[idx_s]) begin
                win[idx_s] = 1'b1;
                win_id     = idx_s;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any = found_s;
    end

endmodule

// File: rtl/dfft_pulse_scheduler.sv
// Shares one DFFT cell between NREQ requesters: arbitrates, sequences the
// set/clk pulses with gap and guard timing, and reports whether out toggled.
module dfft_pulse_scheduler
    import dfft_sched_pkg::*;
#(
    parameter int unsigned NREQ        = DEF_NREQ,
    parameter int unsigned SET_CLK_GAP = DEF_SET_CLK_GAP,
    parameter int unsigned OUT_LAT     = DEF_OUT_LAT,
    parameter int unsigned CT_GUARD    = DEF_CT_GUARD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_bit,
    output logic [NREQ-1:0]         gnt,
    output logic                    dfft_set,
    output logic                    dfft_clk,
    input  logic                    dfft_out,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic                    done_bit,
    output logic                    err
);

    localparam int unsigned IDW = $clog2(NREQ);

    state_t              state_r;
    state_t              next_state_s;
    logic [IDW-1:0]      ptr_r;
    logic [IDW-1:0]      id_r;
    logic                bit_r;
    logic [GAP_W-1:0]    gap_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [GAP_W-1:0]    guard_r;
    logic                out_ref_r;
    logic                prev_out_r;
    logic                seen_edge_r;
    logic                edge_s;
    logic                err_s;

    logic [NREQ-1:0]     win_s;
    logic [IDW-1:0]      win_id_s;
    logic                any_s;

    logic [NREQ-1:0]     gnt_r;
    logic                set_r;
    logic                clk_r;
    logic                done_r;
    logic [IDW-1:0]      done_id_r;
    logic                done_bit_r;
    logic                err_r;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req),
        .ptr    (ptr_r),
        .win    (win_s),
        .win_id (win_id_s),
        .any    (any_s)
    );

    assign edge_s = dfft_out ^ prev_out_r;

    // Next-state decode for the transaction sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s && (guard_r == 4'd0)) begin
                    next_state_s = ST_SET;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SET: begin
                if (SET_CLK_GAP == 32'd0) begin
                    next_state_s = ST_CLK;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == 4'd1) begin
                    next_state_s = ST_CLK;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_CLK:  next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt_r == 5'd1) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Protocol check: one edge is allowed in WAIT, any in RESP, none elsewhere.
    always_comb begin
        err_s = 1'b0;
        case (state_r)
            ST_WAIT: err_s = edge_s && seen_edge_r;
            ST_RESP: err_s = 1'b0;
            default: err_s = edge_s;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Transaction context, counters and edge tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= '0;
            id_r        <= '0;
            bit_r       <= 1'b0;
            gap_cnt_r   <= '0;
            wait_cnt_r  <= '0;
            guard_r     <= '0;
            out_ref_r   <= 1'b0;
            seen_edge_r <= 1'b0;
            // Track the pin through reset so release does not look like an edge.
            prev_out_r  <= dfft_out;
        end else begin
            prev_out_r <= dfft_out;

            if ((state_r == ST_IDLE) && (next_state_s == ST_SET)) begin
                id_r  <= win_id_s;
                bit_r <= req_bit[win_id_s];
            end

            if (state_r == ST_SET) begin
                if (id_r == IDW'(NREQ - 1)) begin
                    ptr_r <= '0;
                end else begin
                    ptr_r <= id_r + IDW'(1);
                end
            end

            if (state_r == ST_SET) begin
                gap_cnt_r <= GAP_W'(SET_CLK_GAP);
            end else if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r - 4'd1;
            end

            if (state_r == ST_CLK) begin
                wait_cnt_r <= WAIT_W'(OUT_LAT);
            end else if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r - 5'd1;
            end

            // Guard is already at CT_GUARD during the clk-pulse cycle, so the
            // earliest following set is CT_GUARD+1 cycles after clk.
            if (next_state_s == ST_CLK) begin
                guard_r <= GAP_W'(CT_GUARD);
            end else if (guard_r != 4'd0) begin
                guard_r <= guard_r - 4'd1;
            end

            if (state_r == ST_CLK) begin
                out_ref_r   <= dfft_out;
                seen_edge_r <= 1'b0;
            end else if ((state_r == ST_WAIT) && edge_s) begin
                seen_edge_r <= 1'b1;
            end
        end
    end

    // Registered outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r      <= '0;
            set_r      <= 1'b0;
            clk_r      <= 1'b0;
            done_r     <= 1'b0;
            done_id_r  <= '0;
            done_bit_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            gnt_r      <= (next_state_s == ST_SET) ? win_s : '0;
            set_r      <= (next_state_s == ST_SET) ? req_bit[win_id_s] : 1'b0;
            clk_r      <= (next_state_s == ST_CLK);
            done_r     <= (next_state_s == ST_RESP);
            done_id_r  <= (next_state_s == ST_RESP) ? id_r : '0;
            done_bit_r <= (next_state_s == ST_RESP) ? (dfft_out != out_ref_r) : 1'b0;
            err_r      <= err_r | err_s;
        end
    end

    assign gnt      = gnt_r;
    assign dfft_set = set_r;
    assign dfft_clk = clk_r;
    assign done     = done_r;
    assign done_id  = done_id_r;
    assign done_bit = done_bit_r;
    assign err      = err_r;

endmodule

// File: tb/tb_dfft_pulse_scheduler.sv
// Directed bench for dfft_pulse_scheduler: default instance plus a
// guard-dominated instance (CT_GUARD=15, OUT_LAT=1).
module tb_dfft_pulse_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [3:0] req = 4'b0, req_bit = 4'b0, gnt;
    logic       dfft_set, dfft_clk, dfft_out = 1'b0, done, done_bit, err;
    logic [1:0] done_id;

    logic [3:0] req_g = 4'b0, req_bit_g = 4'b0, gnt_g;
    logic       set_g, clk_g, out_g = 1'b0, done_g, done_bit_g, err_g;
    logic [1:0] done_id_g;

    int nchecks = 0;
    int nerrors = 0;
    int viol    = 0;

    always #5 clk = ~clk;

    dfft_pulse_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .req_bit(req_bit), .gnt(gnt),
        .dfft_set(dfft_set), .dfft_clk(dfft_clk), .dfft_out(dfft_out),
        .done(done), .done_id(done_id), .done_bit(done_bit), .err(err)
    );

    dfft_pulse_scheduler #(.NREQ(4), .SET_CLK_GAP(2), .OUT_LAT(1), .CT_GUARD(15)) dut_g (
        .clk(clk), .rst(rst), .req(req_g), .req_bit(req_bit_g), .gnt(gnt_g),
        .dfft_set(set_g), .dfft_clk(clk_g), .dfft_out(out_g),
        .done(done_g), .done_id(done_id_g), .done_bit(done_bit_g), .err(err_g)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] bits;
        int         tog;
        logic [3:0] exp_gnt;
        logic       exp_set;
        logic [1:0] exp_id;
        logic       exp_dbit;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        req   = 4'b0;
        req_g = 4'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Invariants: no set+clk overlap, no done with gnt, set only with gnt.
    always @(negedge clk) begin
        if (!rst) begin
            if (dfft_set && dfft_clk) viol++;
            if (done && (gnt != 4'b0)) viol++;
            if (dfft_set && (gnt == 4'b0)) viol++;
            if (set_g && clk_g) viol++;
            if (done_g && (gnt_g != 4'b0)) viol++;
            if (set_g && (gnt_g == 4'b0)) viol++;
        end
    end

    initial begin
        int gnt_k, set_cnt, clk_k, clk_cnt, done_k, done_cnt;
        logic [3:0] gnt_val;
        logic [1:0] id_v;
        logic       dbit_v;
        int gk[5];
        logic [3:0] gv[5];
        int ng;
        int sk[3];
        int ck[3];
        int ns, nc, cnt_clk, cnt_done;

        // req, bits, toggles, gnt, set, id, done_bit, err
        vecs[0] = '{4'b0100, 4'b0100, 1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[1] = '{4'b0100, 4'b0000, 0, 4'b0100, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[2] = '{4'b1010, 4'b1000, 0, 4'b0010, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[3] = '{4'b1000, 4'b1000, 1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
        vecs[4] = '{4'b0001, 4'b0001, 2, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1};
        vecs[5] = '{4'b1111, 4'b0001, 1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0};

        do_reset();
        check("reset_outputs", {24'b0, gnt, dfft_set, dfft_clk, done, done_bit},
              32'd0);
        check("reset_id_err", {29'b0, done_id, err}, 32'd0);

        // Single transactions from a freshly reset scheduler.
        for (int v = 0; v < 6; v++) begin
            if (v != 0) do_reset();
            req = vecs[v].req;
            req_bit = vecs[v].bits;
            gnt_k = -1; gnt_val = 4'b0; set_cnt = 0; clk_k = -1; clk_cnt = 0;
            done_k = -1; done_cnt = 0; id_v = 2'b0; dbit_v = 1'b0;
            for (int k = 1; k <= 16; k++) begin
                @(negedge clk);
                if ((gnt != 4'b0) && (gnt_k < 0)) begin gnt_k = k; gnt_val = gnt; end
                if (dfft_set) set_cnt++;
                if (dfft_clk) begin clk_cnt++; if (clk_k < 0) clk_k = k; end
                if (done) begin
                    done_cnt++;
                    if (done_k < 0) begin done_k = k; id_v = done_id; dbit_v = done_bit; end
                end
                if (k == 1) req = 4'b0;
                if ((k == 11) && (vecs[v].tog >= 1)) dfft_out = ~dfft_out;
                if ((k == 12) && (vecs[v].tog >= 2)) dfft_out = ~dfft_out;
            end
            check($sformatf("v%0d gnt_cycle", v), gnt_k, 32'd1);
            check($sformatf("v%0d gnt_value", v), {28'b0, gnt_val}, {28'b0, vecs[v].exp_gnt});
            check($sformatf("v%0d set_count", v), set_cnt, {31'b0, vecs[v].exp_set});
            check($sformatf("v%0d clk_cycle", v), clk_k, 32'd4);
            check($sformatf("v%0d clk_count", v), clk_cnt, 32'd1);
            check($sformatf("v%0d done_cycle", v), done_k, 32'd13);
            check($sformatf("v%0d done_count", v), done_cnt, 32'd1);
            check($sformatf("v%0d done_id", v), {30'b0, id_v}, {30'b0, vecs[v].exp_id});
            check($sformatf("v%0d done_bit", v), {31'b0, dbit_v}, {31'b0, vecs[v].exp_dbit});
            check($sformatf("v%0d err", v), {31'b0, err}, {31'b0, vecs[v].exp_err});
        end

        // Round robin with every request held high.
        do_reset();
        req = 4'b1111;
        req_bit = 4'b0000;
        ng = 0;
        for (int i = 0; i < 5; i++) begin gk[i] = -100; gv[i] = 4'b0; end
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if ((gnt != 4'b0) && (ng < 5)) begin gk[ng] = k; gv[ng] = gnt; ng++; end
        end
        req = 4'b0;
        check("rr_grant_count", ng, 32'd5);
        check("rr_first_cycle", gk[0], 32'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_order%0d", i), {28'b0, gv[i]}, 32'd1 << (i % 4));
        end
        for (int i = 1; i < 5; i++) begin
            check($sformatf("rr_spacing%0d", i), gk[i] - gk[i-1], 32'd14);
        end

        // Reset during GAP aborts the transaction and clears the pointer.
        do_reset();
        req = 4'b0100;
        req_bit = 4'b0100;
        @(negedge clk);
        check("abort_gnt", {28'b0, gnt}, 32'd4);
        req = 4'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs_zero",
              {24'b0, gnt, dfft_set, dfft_clk, done, done_bit}, 32'd0);
        rst = 1'b0;
        cnt_clk = 0;
        cnt_done = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (dfft_clk) cnt_clk++;
            if (done) cnt_done++;
        end
        check("abort_no_clk", cnt_clk, 32'd0);
        check("abort_no_done", cnt_done, 32'd0);
        req = 4'b1001;
        req_bit = 4'b0000;
        @(negedge clk);
        check("abort_next_gnt_req0", {28'b0, gnt}, 32'd1);
        req = 4'b0;

        // Edge on out while IDLE is a sticky protocol error.
        do_reset();
        check("idle_err_before", {31'b0, err}, 32'd0);
        dfft_out = ~dfft_out;
        repeat (2) @(negedge clk);
        check("idle_err_set", {31'b0, err}, 32'd1);
        repeat (10) @(negedge clk);
        check("idle_err_sticky", {31'b0, err}, 32'd1);
        do_reset();
        check("idle_err_cleared", {31'b0, err}, 32'd0);

        // Guard-dominated instance: set follows previous clk by CT_GUARD+1.
        do_reset();
        req_g = 4'b0001;
        req_bit_g = 4'b0001;
        ns = 0;
        nc = 0;
        for (int i = 0; i < 3; i++) begin sk[i] = -100; ck[i] = -100; end
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (set_g && (ns < 3)) begin sk[ns] = k; ns++; end
            if (clk_g && (nc < 3)) begin ck[nc] = k; nc++; end
        end
        req_g = 4'b0;
        check("guard_first_set", sk[0], 32'd1);
        check("guard_first_clk", ck[0], 32'd4);
        check("guard_set2_after_clk1", sk[1] - ck[0], 32'd16);
        check("guard_set3_after_clk2", sk[2] - ck[1], 32'd16);
        check("guard_err", {31'b0, err_g}, 32'd0);

        check("invariants", viol, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
